// File: rtl/seq_detect_arbiter.sv
// Round-robin arbiter that lends one shared Moore sequence detector to four
// serial requesters, frames each grant, and reports the detection count per frame.
module seq_detect_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] bit_in,
  input  logic [3:0] bit_vld,
  input  logic [3:0] last,
  output logic [3:0] grant,
  output logic       det_clr,
  output logic       det_en,
  output logic       det_x,
  input  logic       det_y,
  output logic       done,
  output logic [1:0] done_id,
  output logic [7:0] match_cnt,
  output logic       aborted
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, REPORT} state_t;

  state_t     state;
  logic [1:0] g, rr_ptr, pick;
  logic       pick_vld, en_d, acc_last;
  logic [7:0] cnt, cnt_nxt;

  // Nearest requester above rr_ptr wins; rr_ptr itself has lowest priority.
  always_comb begin
    logic [1:0] cand;
    pick     = rr_ptr;
    pick_vld = 1'b0;
    cand     = rr_ptr;
    for (int i = 4; i >= 1; i--) begin
      cand = rr_ptr + i[1:0];
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign det_clr  = (state == CLEAR);
  assign det_en   = (state == STREAM) & bit_vld[g];
  assign det_x    = (state == STREAM) & bit_in[g];
  assign acc_last = det_en & last[g];

  // en_d qualifies det_y so a level held across idle bit slots counts once.
  assign cnt_nxt = (en_d && det_y && cnt != 8'hff) ? cnt + 8'd1 : cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      g         <= '0;
      rr_ptr    <= 2'd3;
      en_d      <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
      aborted   <= 1'b0;
    end else begin
      en_d <= det_en;
      cnt  <= cnt_nxt;
      done <= 1'b0;
      case (state)
        IDLE: if (pick_vld) begin
          g     <= pick;
          grant <= 4'd1 << pick;
          state <= CLEAR;
        end
        CLEAR: begin
          cnt   <= '0;
          state <= STREAM;
        end
        STREAM: begin
          if (acc_last) begin
            state <= DRAIN;
          end else if (!req[g]) begin
            state     <= REPORT;
            done      <= 1'b1;
            done_id   <= g;
            match_cnt <= cnt_nxt;
            aborted   <= 1'b1;
          end
        end
        DRAIN: begin
          state     <= REPORT;
          done      <= 1'b1;
          done_id   <= g;
          match_cnt <= cnt_nxt;
          aborted   <= 1'b0;
        end
        REPORT: begin
          rr_ptr <= g;
          grant  <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_detect_arbiter.md
SEQ_DETECT_ARBITER -- requirements
Module: seq_detect_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-004 req  input  4  per-requester request for the shared detector; held high for the whole frame.
REQ-005 bit_in  input  4  serial data bit per requester.
REQ-006 bit_vld  input  4  per-requester bit-valid qualifier.
REQ-007 last  input  4  per-requester end-of-frame flag, qualified by bit_vld.
REQ-008 grant  output  4  one-hot owner of the detector; all zeros when the detector is not owned.
REQ-009 det_clr  output  1  one-cycle clear pulse to the shared Moore detector.
REQ-010 det_en  output  1  detector clock-enable; the detector samples det_x only when det_en=1.
REQ-011 det_x  output  1  serial bit forwarded to the detector.
REQ-012 det_y  input  1  registered Moore detector output; valid the cycle after an enabled sample.
REQ-013 done  output  1  one-cycle frame-complete strobe.
REQ-014 done_id  output  2  index of the requester that finished; valid with done.
REQ-015 match_cnt  output  8  number of detections in the frame; valid with done.
REQ-016 aborted  output  1  frame ended by request withdrawal; valid with done.

Function
REQ-017 The block SHALL implement a registered FSM with states IDLE, CLEAR, STREAM, DRAIN and REPORT.
REQ-018 In IDLE with req!=0, the block SHALL pick a winner round-robin, searching upward from rr_ptr+1 mod 4, then register grant and go to CLEAR.
REQ-019 In IDLE with req==0, the block SHALL remain in IDLE with grant=0.
REQ-020 In CLEAR, the block SHALL drive det_clr=1 for exactly one cycle, clear the match counter, and go to STREAM.
REQ-021 In STREAM, det_en SHALL equal bit_vld[g] and det_x SHALL equal bit_in[g], where g is the granted index; det_en and det_x SHALL be 0 in all other states.
REQ-022 Bits, bit_vld and last from non-granted requesters SHALL be ignored.
REQ-023 The block SHALL register en_d <= det_en, and increment the match counter in any cycle where en_d=1 and det_y=1, so a held-high det_y is not recounted.
REQ-024 The match counter SHALL saturate at 255.
REQ-025 In STREAM, an accepted bit with last[g]=1 SHALL move the FSM to DRAIN.
REQ-026 In STREAM, req[g]=0 with no accepted last that cycle SHALL move the FSM to REPORT with aborted=1.
REQ-027 When an accepted last coincides with req[g] falling in the same cycle, last SHALL win and the frame SHALL not be aborted.
REQ-028 DRAIN SHALL last one cycle, so det_y for the final bit is counted, and then go to REPORT.
REQ-029 In REPORT, the block SHALL drive done=1, done_id=g, match_cnt and aborted for one cycle, set rr_ptr=g and grant=0, and return to IDLE.
REQ-030 Minimum latency SHALL be: req at edge t gives grant at t+1, det_clr in cycle t+1, first bit accepted at t+2, and done 2 cycles after the edge that accepts last.
REQ-031 A new grant SHALL require a return to IDLE, leaving at least one idle cycle between frames.

Reset
REQ-032 reset=1 SHALL force state IDLE, grant=0, rr_ptr=3 (requester 0 wins first), en_d=0, counter=0, done=0, done_id=0, match_cnt=0, aborted=0, det_clr=0, det_en=0 and det_x=0.
REQ-033 reset SHALL take effect in any state, including mid-frame; no done is issued for the interrupted frame, and the detector is reset by the same system reset.

Verification
REQ-034 The bench SHALL cover: req=4'b0001, frame 0,1,1,1,0,1,1,1 with last on the 8th bit and the 0111 detector attached -> done with done_id=0, match_cnt=2, aborted=0.
REQ-035 The bench SHALL cover: req=4'b1111 held across four single-bit frames -> grants in order 0,1,2,3, each grant one-hot.
REQ-036 The bench SHALL cover: requester 2 drops req after 3 accepted bits -> done with aborted=1, done_id=2, and the next grant goes to requester 3.
REQ-037 The bench SHALL cover: bit_vld gaps inside a 0111 frame, with det_y held high while det_en=0 -> match_cnt=1, not recounted.
REQ-038 The bench SHALL cover: 300 back-to-back 0111 patterns in one frame -> match_cnt=255 (saturated).
REQ-039 The bench SHALL cover: reset asserted mid-STREAM -> the next cycle shows grant=0 and all outputs 0, with no done.
